// File: rtl/mux_n_reg_pkg.sv
// mux_n_reg_pkg: shared state encoding and select-width helper for the registered mux models
package mux_n_reg_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mux_n_reg_skid_buf.sv
// mux_n_reg_skid_buf: two-entry skid buffer (main register + skid entry) with valid/ready handshake
//   in_data_i/in_valid_i/in_ready_o : upstream side, in_ready_o registered
//   out_data_o/out_valid_o/out_ready_i : downstream side, out_data_o/out_valid_o registered
module mux_n_reg_skid_buf
  import mux_n_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);
  state_e           state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             valid_q;
  logic             ready_q;
  logic             acc;
  logic             drain;
  assign acc         = in_valid_i && ready_q;
  assign drain       = valid_q && out_ready_i;
  assign in_ready_o  = ready_q;
  assign out_data_o  = main_q;
  assign out_valid_o = valid_q;
  // ready_q is the registered image of "next state is not TWO"
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          ready_q <= 1'b1;
          if (acc) begin
            main_q  <= in_data_i;
            valid_q <= 1'b1;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (acc && drain) main_q <= in_data_i;
          else if (acc) begin
            skid_q  <= in_data_i;
            ready_q <= 1'b0;
            state_q <= TWO;
          end else if (drain) begin
            valid_q <= 1'b0;
            state_q <= EMPTY;
          end
        end
        default: if (drain) begin
          main_q  <= skid_q;
          ready_q <= 1'b1;
          state_q <= ONE;
        end
      endcase
    end
endmodule

// File: rtl/mux_n_reg.sv
// mux_n_reg: registered N:1 mux with valid/ready handshake, skid buffer and sticky bad-select flag
//   I/S/I_VALID/I_READY : lane bus (lane k at [k*WIDTH +: WIDTH]), select, upstream handshake
//   O/O_VALID/O_READY   : selected word and downstream handshake, all outputs registered
//   ERR/ERR_CLR         : sticky out-of-range select flag and its synchronous clear
(* whitebox, MODEL_NAME = "mux_n_reg" *)
module mux_n_reg
  import mux_n_reg_pkg::*;
#(
  parameter int                WIDTH       = 8,
  parameter int                N_INPUTS    = 4,
  parameter logic [WIDTH-1:0]  DEFAULT_VAL = '0,
  localparam int               SEL_W       = sel_width(N_INPUTS)
) (
  (* clock *)
  input  logic                      CLK,
  input  logic                      RST_N,
  (* SETUP = "CLK 10e-12", HOLD = "CLK 10e-12" *)
  input  logic [N_INPUTS*WIDTH-1:0] I,
  (* SETUP = "CLK 10e-12", HOLD = "CLK 10e-12" *)
  input  logic [SEL_W-1:0]          S,
  (* SETUP = "CLK 10e-12", HOLD = "CLK 10e-12" *)
  input  logic                      I_VALID,
  (* CLK_TO_Q = "CLK 10e-12" *)
  output logic                      I_READY,
  (* CLK_TO_Q = "CLK 10e-12" *)
  output logic [WIDTH-1:0]          O,
  (* CLK_TO_Q = "CLK 10e-12" *)
  output logic                      O_VALID,
  (* SETUP = "CLK 10e-12", HOLD = "CLK 10e-12" *)
  input  logic                      O_READY,
  (* CLK_TO_Q = "CLK 10e-12" *)
  output logic                      ERR,
  (* SETUP = "CLK 10e-12", HOLD = "CLK 10e-12" *)
  input  logic                      ERR_CLR
);
  logic             sel_ok;
  logic [WIDTH-1:0] word;
  logic             err_q;
  assign sel_ok = int'(S) < N_INPUTS;
  assign word   = sel_ok ? I[int'(S)*WIDTH +: WIDTH] : DEFAULT_VAL;
  assign ERR    = err_q;
  // a bad select on an accepted word beats a same-cycle clear
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) err_q <= 1'b0;
    else err_q <= (I_VALID && I_READY && !sel_ok) || (err_q && !ERR_CLR);
  mux_n_reg_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clk        (CLK),
    .rst_n      (RST_N),
    .in_data_i  (word),
    .in_valid_i (I_VALID),
    .in_ready_o (I_READY),
    .out_data_o (O),
    .out_valid_o(O_VALID),
    .out_ready_i(O_READY)
  );
endmodule

// File: tb/tb_mux_n_reg.sv
// tb_mux_n_reg: directed and randomized checks of mux_n_reg against a queue-based model
module tb_mux_n_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  logic [31:0] a_i = 32'h44332211;
  logic [1:0]  a_s = '0;
  logic        a_iv = 1'b0, a_ir, a_ov, a_or = 1'b0, a_err, a_clr = 1'b0;
  logic [7:0]  a_o;
  logic [23:0] b_i = 24'h332211;
  logic [1:0]  b_s = '0;
  logic        b_iv = 1'b0, b_ir, b_ov, b_or = 1'b0, b_err, b_clr = 1'b0;
  logic [7:0]  b_o;
  logic [64:0] c_i = '0;
  logic [2:0]  c_s = '0;
  logic        c_iv = 1'b0, c_ir, c_ov, c_or = 1'b0, c_err, c_clr = 1'b0;
  logic [12:0] c_o;
  localparam logic [12:0] C_DEF = 13'h1A5A;
  mux_n_reg #(.WIDTH(8), .N_INPUTS(4)) dut_a (
    .CLK(clk), .RST_N(rst_n), .I(a_i), .S(a_s), .I_VALID(a_iv), .I_READY(a_ir),
    .O(a_o), .O_VALID(a_ov), .O_READY(a_or), .ERR(a_err), .ERR_CLR(a_clr));
  mux_n_reg #(.WIDTH(8), .N_INPUTS(3), .DEFAULT_VAL(8'hA5)) dut_b (
    .CLK(clk), .RST_N(rst_n), .I(b_i), .S(b_s), .I_VALID(b_iv), .I_READY(b_ir),
    .O(b_o), .O_VALID(b_ov), .O_READY(b_or), .ERR(b_err), .ERR_CLR(b_clr));
  mux_n_reg #(.WIDTH(13), .N_INPUTS(5), .DEFAULT_VAL(C_DEF)) dut_c (
    .CLK(clk), .RST_N(rst_n), .I(c_i), .S(c_s), .I_VALID(c_iv), .I_READY(c_ir),
    .O(c_o), .O_VALID(c_ov), .O_READY(c_or), .ERR(c_err), .ERR_CLR(c_clr));

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL rst_ov got %b want 0", a_ov); end
    n_cmp++; if (a_o !== 8'h00) begin n_fail++; $display("FAIL rst_o got %h want 00", a_o); end
    n_cmp++; if (a_ir !== 1'b0) begin n_fail++; $display("FAIL rst_ir_low got %b want 0", a_ir); end
    n_cmp++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", a_err); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({a_ir, b_ir, c_ir} !== 3'b111) begin n_fail++; $display("FAIL rst_ir_rel got %b want 111", {a_ir, b_ir, c_ir}); end
    n_cmp++; if ({a_ov, b_ov, c_ov} !== 3'b000) begin n_fail++; $display("FAIL rst_ov_rel got %b want 000", {a_ov, b_ov, c_ov}); end
  endtask

  task automatic test_basic();
    logic [1:0] sel[4] = '{2'd2, 2'd0, 2'd1, 2'd3};
    logic [7:0] exp[4] = '{8'h33, 8'h11, 8'h22, 8'h44};
    a_iv = 1'b1; a_s = sel[0]; a_or = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++; if (a_ov !== 1'b1) begin n_fail++; $display("FAIL basic_ov[%0d] got %b want 1", k, a_ov); end
      n_cmp++; if (a_o !== exp[k]) begin n_fail++; $display("FAIL basic_o[%0d] got %h want %h", k, a_o, exp[k]); end
      n_cmp++; if (a_ir !== 1'b1) begin n_fail++; $display("FAIL basic_ir[%0d] got %b want 1", k, a_ir); end
      if (k < 3) a_s = sel[k+1]; else a_iv = 1'b0;
    end
    @(negedge clk);
    n_cmp++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL basic_drained got %b want 0", a_ov); end
  endtask

  task automatic test_backpressure();
    a_or = 1'b0; a_iv = 1'b1; a_s = 2'd0;
    @(negedge clk);
    n_cmp++; if (a_o !== 8'h11 || a_ov !== 1'b1) begin n_fail++; $display("FAIL bp_first got %h/%b want 11/1", a_o, a_ov); end
    n_cmp++; if (a_ir !== 1'b1) begin n_fail++; $display("FAIL bp_ir1 got %b want 1", a_ir); end
    a_s = 2'd1;
    @(negedge clk);
    n_cmp++; if (a_ir !== 1'b0) begin n_fail++; $display("FAIL bp_ir_full got %b want 0", a_ir); end
    n_cmp++; if (a_o !== 8'h11) begin n_fail++; $display("FAIL bp_hold1 got %h want 11", a_o); end
    a_s = 2'd3;
    @(negedge clk);
    n_cmp++; if (a_ir !== 1'b0) begin n_fail++; $display("FAIL bp_ir_third got %b want 0", a_ir); end
    n_cmp++; if (a_o !== 8'h11 || a_ov !== 1'b1) begin n_fail++; $display("FAIL bp_hold2 got %h/%b want 11/1", a_o, a_ov); end
    a_or = 1'b1;
    @(negedge clk);
    n_cmp++; if (a_o !== 8'h22 || a_ov !== 1'b1) begin n_fail++; $display("FAIL bp_second got %h/%b want 22/1", a_o, a_ov); end
    n_cmp++; if (a_ir !== 1'b1) begin n_fail++; $display("FAIL bp_ir_back got %b want 1", a_ir); end
    @(negedge clk);
    n_cmp++; if (a_o !== 8'h44 || a_ov !== 1'b1) begin n_fail++; $display("FAIL bp_third got %h/%b want 44/1", a_o, a_ov); end
    a_iv = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", a_ov); end
  endtask

  task automatic test_err();
    b_or = 1'b1; b_iv = 1'b1; b_s = 2'd3;
    @(negedge clk);
    n_cmp++; if (b_o !== 8'hA5 || b_ov !== 1'b1) begin n_fail++; $display("FAIL err_default got %h/%b want a5/1", b_o, b_ov); end
    n_cmp++; if (b_err !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", b_err); end
    b_iv = 1'b0;
    @(negedge clk);
    n_cmp++; if (b_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", b_err); end
    b_clr = 1'b1;
    @(negedge clk);
    n_cmp++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL err_clr got %b want 0", b_err); end
    b_clr = 1'b0; b_iv = 1'b1; b_s = 2'd1;
    @(negedge clk);
    n_cmp++; if (b_o !== 8'h22 || b_err !== 1'b0) begin n_fail++; $display("FAIL err_good_sel got %h/%b want 22/0", b_o, b_err); end
    b_s = 2'd3; b_clr = 1'b1;
    @(negedge clk);
    n_cmp++; if (b_err !== 1'b1) begin n_fail++; $display("FAIL err_set_wins got %b want 1", b_err); end
    b_iv = 1'b0;
    @(negedge clk);
    n_cmp++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL err_clr2 got %b want 0", b_err); end
    b_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    a_or = 1'b0; a_iv = 1'b1; a_s = 2'd0;
    @(negedge clk);
    a_s = 2'd1;
    @(negedge clk);
    n_cmp++; if (a_ir !== 1'b0 || a_ov !== 1'b1) begin n_fail++; $display("FAIL rm_full got ir=%b ov=%b want 0/1", a_ir, a_ov); end
    a_iv = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (a_ov !== 1'b0 || a_o !== 8'h00) begin n_fail++; $display("FAIL rm_async got %h/%b want 00/0", a_o, a_ov); end
    n_cmp++; if (a_ir !== 1'b0) begin n_fail++; $display("FAIL rm_ir_low got %b want 0", a_ir); end
    @(negedge clk);
    rst_n = 1'b1; a_or = 1'b1;
    @(negedge clk);
    n_cmp++; if (a_ir !== 1'b1 || a_ov !== 1'b0) begin n_fail++; $display("FAIL rm_release got ir=%b ov=%b want 1/0", a_ir, a_ov); end
    @(negedge clk);
    n_cmp++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL rm_no_stale got %b want 0", a_ov); end
  endtask

  task automatic test_random();
    logic [12:0] q[$];
    logic [12:0] lane[5];
    logic [12:0] prev_o;
    logic rdy_exp, err_exp, acc, hold;
    q = {}; rdy_exp = 1'b1; err_exp = 1'b0; hold = 1'b0; prev_o = '0;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      n_cmp++; if (c_ov !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_ov @%0d got %b want %b", n, c_ov, q.size() != 0); end
      n_cmp++; if (c_ir !== rdy_exp) begin n_fail++; $display("FAIL rnd_ir @%0d got %b want %b", n, c_ir, rdy_exp); end
      n_cmp++; if (c_err !== err_exp) begin n_fail++; $display("FAIL rnd_err @%0d got %b want %b", n, c_err, err_exp); end
      if (q.size() != 0) begin
        n_cmp++; if (c_o !== q[0]) begin n_fail++; $display("FAIL rnd_o @%0d got %h want %h", n, c_o, q[0]); end
      end
      if (hold) begin
        n_cmp++; if (c_o !== prev_o) begin n_fail++; $display("FAIL rnd_stable @%0d got %h want %h", n, c_o, prev_o); end
      end
      for (int k = 0; k < 5; k++) lane[k] = 13'($urandom);
      c_i = {lane[4], lane[3], lane[2], lane[1], lane[0]};
      c_s = 3'($urandom_range(0, 7));
      c_iv = $urandom_range(0, 3) != 0;
      c_or = $urandom_range(0, 2) != 0;
      c_clr = $urandom_range(0, 15) == 0;
      hold = c_ov && !c_or;
      prev_o = c_o;
      acc = c_iv && rdy_exp;
      if (q.size() != 0 && c_or) void'(q.pop_front());
      if (acc) q.push_back(c_s < 5 ? lane[c_s] : C_DEF);
      err_exp = (acc && c_s >= 5) || (err_exp && !c_clr);
      rdy_exp = q.size() < 2;
    end
    c_iv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_err();
    test_reset_mid();
    test_random();
    n_cmp++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL pow2_err got %b want 0", a_err); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
